// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//
// Game-state and score sequencer for Pong. Goal events from the ball logic
// and the start button drive a four-state machine (IDLE, SERVE, PLAY, OVER).
// The machine produces both players' scores for the digit renderers, the
// ball launch pulse and direction, and the game-over indication. Serve timing
// is counted in frame_tick pulses.
//
// Optional feature macro: SCORE_FLASH_EN
//   When defined, the scoring side's digit blinks during the SERVE that
//   follows a point, and the winner's digit blinks while in OVER. When not
//   defined, both visibility outputs are constant 1.
//
// Parameters:
//   WIN_SCORE    - score that ends the game (1..7)
//   SERVE_DELAY  - frame_ticks from entering SERVE to ball release (1..255)
//   FLASH_PERIOD - frame_ticks per half-period of the digit flash
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse, once per video frame
//   start         in   one-cycle start request
//   goal_left     in   ball passed left edge (right player scores)
//   goal_right    in   ball passed right edge (left player scores)
//   score_left    out  left player score  [2:0]
//   score_right   out  right player score [2:0]
//   ball_release  out  one-cycle launch pulse
//   serve_dir     out  launch direction (0 = toward left, 1 = toward right)
//   game_over     out  high while in OVER
//   winner        out  0 = left won, 1 = right won (valid with game_over)
//   left_visible  out  display enable for the left score digit
//   right_visible out  display enable for the right score digit
// ---------------------------------------------------------------------------
module score_keeper #(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_DELAY  = 60,
   parameter int FLASH_PERIOD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       goal_left,
   input  logic       goal_right,
   output logic [2:0] score_left,
   output logic [2:0] score_right,
   output logic       ball_release,
   output logic       serve_dir,
   output logic       game_over,
   output logic       winner,
   output logic       left_visible,
   output logic       right_visible
);

   localparam logic [2:0] WIN_VAL   = WIN_SCORE[2:0];
   localparam logic [7:0] DELAY_VAL = SERVE_DELAY[7:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SERVE = 2'd1,
      S_PLAY  = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] score_left_q, score_left_d;
   logic [2:0] score_right_q, score_right_d;
   logic       ball_release_q, ball_release_d;
   logic       serve_dir_q, serve_dir_d;
   logic       game_over_q, game_over_d;
   logic       winner_q, winner_d;

   // Events handed to the flash logic: a point was scored (flash_start,
   // with the scoring side in flash_side) or a new game was started from
   // OVER (flash_clr).
   logic       flash_start;
   logic       flash_side;
   logic       flash_clr;

   // -----------------------------------------------------------------------
   // Next-state and output logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      score_left_d   = score_left_q;
      score_right_d  = score_right_q;
      ball_release_d = 1'b0;
      serve_dir_d    = serve_dir_q;
      game_over_d    = game_over_q;
      winner_d       = winner_q;
      flash_start    = 1'b0;
      flash_side     = 1'b0;
      flash_clr      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = DELAY_VAL;
               state_d = S_SERVE;
            end
         end

         S_SERVE: begin
            // Goals and start are ignored here; only the countdown runs.
            if (frame_tick) begin
               if (cnt_q == 8'd1) begin
                  cnt_d          = 8'd0;
                  ball_release_d = 1'b1;
                  state_d        = S_PLAY;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end

         S_PLAY: begin
            // goal_left wins when both goals arrive together.
            if (goal_left) begin
               score_right_d = score_right_q + 3'd1;
               serve_dir_d   = 1'b0;
               flash_start   = 1'b1;
               flash_side    = 1'b1;
               if (score_right_d == WIN_VAL) begin
                  game_over_d = 1'b1;
                  winner_d    = 1'b1;
                  state_d     = S_OVER;
               end else begin
                  cnt_d   = DELAY_VAL;
                  state_d = S_SERVE;
               end
            end else if (goal_right) begin
               score_left_d = score_left_q + 3'd1;
               serve_dir_d  = 1'b1;
               flash_start  = 1'b1;
               flash_side   = 1'b0;
               if (score_left_d == WIN_VAL) begin
                  game_over_d = 1'b1;
                  winner_d    = 1'b0;
                  state_d     = S_OVER;
               end else begin
                  cnt_d   = DELAY_VAL;
                  state_d = S_SERVE;
               end
            end
         end

         S_OVER: begin
            if (start) begin
               score_left_d  = 3'd0;
               score_right_d = 3'd0;
               game_over_d   = 1'b0;
               serve_dir_d   = 1'b1;
               cnt_d         = DELAY_VAL;
               flash_clr     = 1'b1;
               state_d       = S_SERVE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= 8'd0;
         score_left_q   <= 3'd0;
         score_right_q  <= 3'd0;
         ball_release_q <= 1'b0;
         serve_dir_q    <= 1'b1;
         game_over_q    <= 1'b0;
         winner_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         score_left_q   <= score_left_d;
         score_right_q  <= score_right_d;
         ball_release_q <= ball_release_d;
         serve_dir_q    <= serve_dir_d;
         game_over_q    <= game_over_d;
         winner_q       <= winner_d;
      end
   end

   assign score_left   = score_left_q;
   assign score_right  = score_right_q;
   assign ball_release = ball_release_q;
   assign serve_dir    = serve_dir_q;
   assign game_over    = game_over_q;
   assign winner       = winner_q;

`ifdef SCORE_FLASH_EN
   // -----------------------------------------------------------------------
   // Digit flash: one side blinks while flash_on is set. The blink level
   // starts low on the edge that enters SERVE/OVER and toggles every
   // FLASH_PERIOD frame_ticks.
   // -----------------------------------------------------------------------
   localparam logic [7:0] FLASH_VAL = FLASH_PERIOD[7:0];

   logic       flash_on_q, flash_on_d;
   logic       flash_sel_q, flash_sel_d;
   logic       flash_lvl_q, flash_lvl_d;
   logic [7:0] fcnt_q, fcnt_d;
   logic       left_vis_q, left_vis_d;
   logic       right_vis_q, right_vis_d;

   always_comb begin
      flash_on_d  = flash_on_q;
      flash_sel_d = flash_sel_q;
      flash_lvl_d = flash_lvl_q;
      fcnt_d      = fcnt_q;

      if (flash_start) begin
         flash_on_d  = 1'b1;
         flash_sel_d = flash_side;
         flash_lvl_d = 1'b0;
         fcnt_d      = 8'd0;
      end else if (flash_on_q && frame_tick) begin
         if (fcnt_q == FLASH_VAL - 8'd1) begin
            fcnt_d      = 8'd0;
            flash_lvl_d = ~flash_lvl_q;
         end else begin
            fcnt_d = fcnt_q + 8'd1;
         end
      end

      // Flashing only exists in SERVE and OVER; a restart from OVER is a
      // fresh serve with no scorer to highlight.
      if (flash_clr || (state_d != S_SERVE && state_d != S_OVER)) begin
         flash_on_d = 1'b0;
      end

      left_vis_d  = ~(flash_on_d && !flash_sel_d) | flash_lvl_d;
      right_vis_d = ~(flash_on_d &&  flash_sel_d) | flash_lvl_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flash_on_q  <= 1'b0;
         flash_sel_q <= 1'b0;
         flash_lvl_q <= 1'b1;
         fcnt_q      <= 8'd0;
         left_vis_q  <= 1'b1;
         right_vis_q <= 1'b1;
      end else begin
         flash_on_q  <= flash_on_d;
         flash_sel_q <= flash_sel_d;
         flash_lvl_q <= flash_lvl_d;
         fcnt_q      <= fcnt_d;
         left_vis_q  <= left_vis_d;
         right_vis_q <= right_vis_d;
      end
   end

   assign left_visible  = left_vis_q;
   assign right_visible = right_vis_q;
`else
   // Flash disabled: digits always shown; flash events have no consumer.
   logic unused_flash;
   assign unused_flash  = ^{FLASH_PERIOD, flash_start, flash_side, flash_clr};
   assign left_visible  = 1'b1;
   assign right_visible = 1'b1;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
//
// Directed self-checking bench for score_keeper, built with WIN_SCORE=7,
// SERVE_DELAY=3, FLASH_PERIOD=2. Each scenario task drives its stimulus and
// compares outputs against hand-computed values one cycle after the edge
// that sampled the stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_score_keeper;

   logic       clk;
   logic       rst_n;
   logic       frame_tick;
   logic       start;
   logic       goal_left;
   logic       goal_right;
   logic [2:0] score_left;
   logic [2:0] score_right;
   logic       ball_release;
   logic       serve_dir;
   logic       game_over;
   logic       winner;
   logic       left_visible;
   logic       right_visible;

   int pass_cnt;
   int total_cnt;

   score_keeper #(
      .WIN_SCORE   (7),
      .SERVE_DELAY (3),
      .FLASH_PERIOD(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick   (frame_tick),
      .start        (start),
      .goal_left    (goal_left),
      .goal_right   (goal_right),
      .score_left   (score_left),
      .score_right  (score_right),
      .ball_release (ball_release),
      .serve_dir    (serve_dir),
      .game_over    (game_over),
      .winner       (winner),
      .left_visible (left_visible),
      .right_visible(right_visible)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one cycle of inputs; returns 1ns after the edge that sampled them.
   task automatic step(input logic t, input logic s, input logic gl, input logic gr);
      @(posedge clk);
      #1;
      frame_tick = t;
      start      = s;
      goal_left  = gl;
      goal_right = gr;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      start      = 1'b0;
      goal_left  = 1'b0;
      goal_right = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      frame_tick = 1'b0; start = 1'b0; goal_left = 1'b0; goal_right = 1'b0;
      #23;
      total_cnt++; if (score_left !== 3'd0) $display("FAIL rst_score_left got=%0d exp=0", score_left); else pass_cnt++;
      total_cnt++; if (score_right !== 3'd0) $display("FAIL rst_score_right got=%0d exp=0", score_right); else pass_cnt++;
      total_cnt++; if (ball_release !== 1'b0) $display("FAIL rst_ball_release got=%b exp=0", ball_release); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b1) $display("FAIL rst_serve_dir got=%b exp=1", serve_dir); else pass_cnt++;
      total_cnt++; if (game_over !== 1'b0) $display("FAIL rst_game_over got=%b exp=0", game_over); else pass_cnt++;
      total_cnt++; if (winner !== 1'b0) $display("FAIL rst_winner got=%b exp=0", winner); else pass_cnt++;
      total_cnt++; if ({left_visible, right_visible} !== 2'b11) $display("FAIL rst_visible got=%b%b exp=11", left_visible, right_visible); else pass_cnt++;
      @(posedge clk); #2;
      rst_n = 1'b1;
      // Ticks in IDLE must not release the ball.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== 1'b0) $display("FAIL idle_no_release got=%b exp=0", ball_release); else pass_cnt++;
      end
   endtask

   task automatic test_serve();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      total_cnt++; if (ball_release !== 1'b0) $display("FAIL serve_enter_release got=%b exp=0", ball_release); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b1) $display("FAIL serve_dir_first got=%b exp=1", serve_dir); else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== (i == 3)) $display("FAIL serve_tick%0d_release got=%b exp=%b", i, ball_release, (i == 3)); else pass_cnt++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (ball_release !== 1'b0) $display("FAIL serve_release_one_cycle got=%b exp=0", ball_release); else pass_cnt++;
      // In PLAY, further ticks do not release.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (ball_release !== 1'b0) $display("FAIL play_tick_release got=%b exp=0", ball_release); else pass_cnt++;
   endtask

   task automatic test_goal_play();
      logic vis_exp;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      total_cnt++; if (score_right !== 3'd1) $display("FAIL gl_score_right got=%0d exp=1", score_right); else pass_cnt++;
      total_cnt++; if (score_left !== 3'd0) $display("FAIL gl_score_left got=%0d exp=0", score_left); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b0) $display("FAIL gl_serve_dir got=%b exp=0", serve_dir); else pass_cnt++;
`ifdef SCORE_FLASH_EN
      vis_exp = 1'b0;
`else
      vis_exp = 1'b1;
`endif
      total_cnt++; if (right_visible !== vis_exp) $display("FAIL gl_vis_enter got=%b exp=%b", right_visible, vis_exp); else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== (i == 3)) $display("FAIL gl_tick%0d_release got=%b exp=%b", i, ball_release, (i == 3)); else pass_cnt++;
`ifdef SCORE_FLASH_EN
         vis_exp = (i >= 2);
`else
         vis_exp = 1'b1;
`endif
         total_cnt++; if (right_visible !== vis_exp) $display("FAIL gl_vis_tick%0d got=%b exp=%b", i, right_visible, vis_exp); else pass_cnt++;
         total_cnt++; if (left_visible !== 1'b1) $display("FAIL gl_left_vis_tick%0d got=%b exp=1", i, left_visible); else pass_cnt++;
      end
   endtask

   task automatic test_ignore_serve();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      total_cnt++; if (score_right !== 3'd2) $display("FAIL ig_point got=%0d exp=2", score_right); else pass_cnt++;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      total_cnt++; if ({score_left, score_right} !== {3'd0, 3'd2}) $display("FAIL ig_serve_scores got=%0d,%0d exp=0,2", score_left, score_right); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b0) $display("FAIL ig_serve_dir got=%b exp=0", serve_dir); else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      // A start mid-serve must not reload the countdown.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (ball_release !== 1'b0) $display("FAIL ig_tick2_release got=%b exp=0", ball_release); else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (ball_release !== 1'b1) $display("FAIL ig_tick3_release got=%b exp=1", ball_release); else pass_cnt++;
   endtask

   task automatic test_both_goals();
      step(1'b0, 1'b0, 1'b1, 1'b1);
      total_cnt++; if (score_right !== 3'd3) $display("FAIL both_score_right got=%0d exp=3", score_right); else pass_cnt++;
      total_cnt++; if (score_left !== 3'd0) $display("FAIL both_score_left got=%0d exp=0", score_left); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b0) $display("FAIL both_serve_dir got=%b exp=0", serve_dir); else pass_cnt++;
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (ball_release !== 1'b1) $display("FAIL both_release got=%b exp=1", ball_release); else pass_cnt++;
   endtask

   task automatic test_win_left();
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         total_cnt++; if (score_left !== 3'(k)) $display("FAIL win_l_point%0d got=%0d exp=%0d", k, score_left, k); else pass_cnt++;
         total_cnt++; if (game_over !== (k == 7)) $display("FAIL win_l_game_over%0d got=%b exp=%b", k, game_over, (k == 7)); else pass_cnt++;
         if (k < 7) for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      total_cnt++; if (winner !== 1'b0) $display("FAIL win_l_winner got=%b exp=0", winner); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b1) $display("FAIL win_l_serve_dir got=%b exp=1", serve_dir); else pass_cnt++;
      // OVER: goals and ticks have no effect.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== 1'b0) $display("FAIL over_release got=%b exp=0", ball_release); else pass_cnt++;
      end
      total_cnt++; if ({score_left, score_right} !== {3'd7, 3'd3}) $display("FAIL over_scores got=%0d,%0d exp=7,3", score_left, score_right); else pass_cnt++;
      total_cnt++; if (game_over !== 1'b1) $display("FAIL over_hold got=%b exp=1", game_over); else pass_cnt++;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      total_cnt++; if ({score_left, score_right} !== 6'd0) $display("FAIL restart_scores got=%0d,%0d exp=0,0", score_left, score_right); else pass_cnt++;
      total_cnt++; if (game_over !== 1'b0) $display("FAIL restart_game_over got=%b exp=0", game_over); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b1) $display("FAIL restart_serve_dir got=%b exp=1", serve_dir); else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== (i == 3)) $display("FAIL restart_tick%0d_release got=%b exp=%b", i, ball_release, (i == 3)); else pass_cnt++;
      end
   endtask

   task automatic test_win_right();
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         if (k < 7) for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      total_cnt++; if (score_right !== 3'd7) $display("FAIL win_r_score got=%0d exp=7", score_right); else pass_cnt++;
      total_cnt++; if ({game_over, winner} !== 2'b11) $display("FAIL win_r_over_winner got=%b%b exp=11", game_over, winner); else pass_cnt++;
      total_cnt++; if (score_left !== 3'd0) $display("FAIL win_r_score_left got=%0d exp=0", score_left); else pass_cnt++;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (ball_release !== 1'b1) $display("FAIL win_r_restart_release got=%b exp=1", ball_release); else pass_cnt++;
   endtask

   task automatic test_reset_mid_serve();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (score_right !== 3'd1) $display("FAIL mid_pre_score got=%0d exp=1", score_right); else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (score_right !== 3'd0) $display("FAIL mid_rst_score_right got=%0d exp=0", score_right); else pass_cnt++;
      total_cnt++; if (serve_dir !== 1'b1) $display("FAIL mid_rst_serve_dir got=%b exp=1", serve_dir); else pass_cnt++;
      total_cnt++; if ({ball_release, game_over, winner} !== 3'b000) $display("FAIL mid_rst_ctrl got=%b exp=000", {ball_release, game_over, winner}); else pass_cnt++;
      total_cnt++; if ({left_visible, right_visible} !== 2'b11) $display("FAIL mid_rst_visible got=%b%b exp=11", left_visible, right_visible); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== 1'b0) $display("FAIL mid_rst_hold_release got=%b exp=0", ball_release); else pass_cnt++;
      end
      rst_n = 1'b1;
      // Back in IDLE: ticks alone never release.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== 1'b0) $display("FAIL mid_idle_release got=%b exp=0", ball_release); else pass_cnt++;
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++; if (ball_release !== (i == 3)) $display("FAIL mid_recover_tick%0d got=%b exp=%b", i, ball_release, (i == 3)); else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_serve();
      test_goal_play();
      test_ignore_serve();
      test_both_goals();
      test_win_left();
      test_win_right();
      test_reset_mid_serve();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1, "timeout");
   end

endmodule
